// File: rtl/custom_hls_dispatch_pkg.sv
// rtl/custom_hls_dispatch_pkg.sv - shared register map, job type and kernel state encoding
package custom_hls_dispatch_pkg;

    localparam int unsigned MAX_ARGS = 14;

    localparam logic [7:0] REG_CTRL       = 8'h00;
    localparam logic [7:0] REG_STATUS     = 8'h04;
    localparam logic [7:0] REG_ARG0       = 8'h08;
    localparam logic [7:0] REG_PUSH       = 8'h40;
    localparam logic [7:0] REG_DONE_CNT   = 8'h44;
    localparam logic [7:0] REG_IRQ_STATUS = 8'h48;
    localparam logic [7:0] REG_IRQ_THRESH = 8'h4C;

    // One job: up to MAX_ARGS 32-bit arguments; slots beyond NUM_ARGS stay zero.
    typedef logic [MAX_ARGS-1:0][31:0] job_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } kern_state_e;

endpackage

// File: rtl/custom_hls_job_fifo.sv
// rtl/custom_hls_job_fifo.sv - synchronous job descriptor FIFO with flush
module custom_hls_job_fifo
    import custom_hls_dispatch_pkg::*;
#(
    parameter int unsigned NUM_ARGS    = 4,
    parameter int unsigned QUEUE_DEPTH = 8,
    localparam int unsigned PW         = $clog2(QUEUE_DEPTH)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  job_t        data_i,
    input  logic        pop_i,
    input  logic        flush_i,
    output job_t        data_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [PW:0] count_o
);

    // Only the live argument slots are stored.
    logic [NUM_ARGS-1:0][31:0] mem_q [QUEUE_DEPTH];
    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push, do_pop;

    // Pointers carry an extra MSB so full and empty differ only in that bit.
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (count_o == (PW+1)'(QUEUE_DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    if (NUM_ARGS < MAX_ARGS) begin : g_in_unused
        logic unused_upper;
        assign unused_upper = ^data_i[MAX_ARGS-1:NUM_ARGS];
    end

    // Next pointer values; flush empties the queue and overrides push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are only meaningful between write and read pointer.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= data_i[NUM_ARGS-1:0];
    end

    // Head entry, zero-padded to a full job.
    always_comb begin
        data_o = '0;
        data_o[NUM_ARGS-1:0] = mem_q[rd_ptr_q[PW-1:0]];
    end

endmodule

// File: rtl/custom_hls_job_dispatcher.sv
// rtl/custom_hls_job_dispatcher.sv - AXI-lite job queue dispatching round-robin to ap_ctrl_hs kernels
module custom_hls_job_dispatcher
    import custom_hls_dispatch_pkg::*;
#(
    parameter int unsigned NUM_KERNELS = 2,
    parameter int unsigned NUM_ARGS    = 4,
    parameter int unsigned QUEUE_DEPTH = 8,
    parameter int unsigned ADDR_WIDTH  = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    output logic                             interrupt_o,
    input  logic                             control_axilite_awvalid,
    output logic                             control_axilite_awready,
    input  logic [ADDR_WIDTH-1:0]            control_axilite_awaddr,
    input  logic                             control_axilite_wvalid,
    output logic                             control_axilite_wready,
    input  logic [31:0]                      control_axilite_wdata,
    input  logic [3:0]                       control_axilite_wstrb,
    output logic                             control_axilite_bvalid,
    input  logic                             control_axilite_bready,
    output logic [1:0]                       control_axilite_bresp,
    input  logic                             control_axilite_arvalid,
    output logic                             control_axilite_arready,
    input  logic [ADDR_WIDTH-1:0]            control_axilite_araddr,
    output logic                             control_axilite_rvalid,
    input  logic                             control_axilite_rready,
    output logic [31:0]                      control_axilite_rdata,
    output logic [1:0]                       control_axilite_rresp,
    output logic [NUM_KERNELS-1:0]           kern_ap_start_o,
    input  logic [NUM_KERNELS-1:0]           kern_ap_ready_i,
    input  logic [NUM_KERNELS-1:0]           kern_ap_done_i,
    output logic [NUM_KERNELS*NUM_ARGS*32-1:0] kern_args_o
);

    localparam int unsigned PW = $clog2(QUEUE_DEPTH);
    localparam int unsigned KW = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1;

    logic        gie_q, gie_d;
    job_t        stage_q, stage_d;
    logic [15:0] done_cnt_q, done_cnt_d;
    logic [1:0]  irq_q, irq_d;
    logic [7:0]  thresh_q, thresh_d;
    logic [8:0]  pend_q, pend_d;
    logic        bvalid_q, bvalid_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        irq_out_q, irq_out_d;
    logic [KW-1:0] rr_q, rr_d;
    kern_state_e state_q [NUM_KERNELS];
    kern_state_e state_d [NUM_KERNELS];
    logic [NUM_KERNELS-1:0][NUM_ARGS-1:0][31:0] kargs_q, kargs_d;

    logic        wr_fire, rd_fire;
    logic        flush, push_req;
    logic [1:0]  irq_clr;
    logic        fifo_full, fifo_empty;
    logic [PW:0] fifo_count;
    job_t        fifo_head;
    logic        found, dispatch;
    logic [KW-1:0] sel;
    logic [NUM_KERNELS-1:0] done_valid;
    logic [3:0]  done_inc;
    logic [8:0]  pend_sum;
    logic        set_done, set_ovf;
    logic [31:0] rdata_mux;

    function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] a, input logic [7:0] off);
        return a == ADDR_WIDTH'(off);
    endfunction

    assign wr_fire = control_axilite_awvalid && control_axilite_wvalid && !bvalid_q;
    assign rd_fire = control_axilite_arvalid && !rvalid_q;

    assign control_axilite_awready = wr_fire;
    assign control_axilite_wready  = wr_fire;
    assign control_axilite_bvalid  = bvalid_q;
    assign control_axilite_bresp   = 2'b00;
    assign control_axilite_arready = !rvalid_q;
    assign control_axilite_rvalid  = rvalid_q;
    assign control_axilite_rdata   = rdata_q;
    assign control_axilite_rresp   = 2'b00;
    assign interrupt_o             = irq_out_q;
    assign kern_args_o             = kargs_q;

    if (NUM_ARGS < MAX_ARGS) begin : g_head_unused
        logic unused_head;
        assign unused_head = ^fifo_head[MAX_ARGS-1:NUM_ARGS];
    end

    custom_hls_job_fifo #(
        .NUM_ARGS    (NUM_ARGS),
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push_req),
        .data_i  (stage_q),
        .pop_i   (dispatch),
        .flush_i (flush),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Register writes and the AXI-lite response/read-data channels.
    always_comb begin
        gie_d    = gie_q;
        stage_d  = stage_q;
        thresh_d = thresh_q;
        flush    = 1'b0;
        push_req = 1'b0;
        irq_clr  = 2'b00;
        if (wr_fire) begin
            if (addr_hit(control_axilite_awaddr, REG_CTRL)) begin
                gie_d = control_axilite_wdata[0];
                flush = control_axilite_wdata[1];
            end
            for (int i = 0; i < NUM_ARGS; i++) begin
                if (addr_hit(control_axilite_awaddr, 8'(REG_ARG0 + 4 * i))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (control_axilite_wstrb[b]) stage_d[i][8*b +: 8] = control_axilite_wdata[8*b +: 8];
                    end
                end
            end
            if (addr_hit(control_axilite_awaddr, REG_PUSH)) push_req = 1'b1;
            if (addr_hit(control_axilite_awaddr, REG_IRQ_STATUS)) irq_clr = control_axilite_wdata[1:0];
            if (addr_hit(control_axilite_awaddr, REG_IRQ_THRESH)) begin
                thresh_d = (control_axilite_wdata[7:0] == 8'd0) ? 8'd1 : control_axilite_wdata[7:0];
            end
        end

        rdata_mux = '0;
        if (addr_hit(control_axilite_araddr, REG_CTRL)) rdata_mux[0] = gie_q;
        if (addr_hit(control_axilite_araddr, REG_STATUS)) begin
            rdata_mux[7:0] = 8'(fifo_count);
            rdata_mux[8]   = fifo_full;
            rdata_mux[9]   = fifo_empty;
            for (int k = 0; k < NUM_KERNELS; k++) rdata_mux[16+k] = (state_q[k] != IDLE);
        end
        for (int i = 0; i < NUM_ARGS; i++) begin
            if (addr_hit(control_axilite_araddr, 8'(REG_ARG0 + 4 * i))) rdata_mux = stage_q[i];
        end
        if (addr_hit(control_axilite_araddr, REG_DONE_CNT))   rdata_mux[15:0] = done_cnt_q;
        if (addr_hit(control_axilite_araddr, REG_IRQ_STATUS)) rdata_mux[1:0]  = irq_q;
        if (addr_hit(control_axilite_araddr, REG_IRQ_THRESH)) rdata_mux[7:0]  = thresh_q;

        bvalid_d = wr_fire || (bvalid_q && !control_axilite_bready);
        rvalid_d = rd_fire || (rvalid_q && !control_axilite_rready);
        rdata_d  = rd_fire ? rdata_mux : rdata_q;
    end

    // Round-robin pick of the first idle kernel at or after rr_q, plus per-kernel ap_ctrl_hs FSMs.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int off = 0; off < NUM_KERNELS; off++) begin
            int idx;
            idx = (int'(rr_q) + off) % NUM_KERNELS;
            if (!found && state_q[idx] == IDLE) begin
                found = 1'b1;
                sel   = KW'(idx);
            end
        end
        dispatch = found && !fifo_empty;
        rr_d     = dispatch ? KW'((int'(sel) + 1) % NUM_KERNELS) : rr_q;

        kargs_d    = kargs_q;
        done_valid = '0;
        for (int k = 0; k < NUM_KERNELS; k++) begin
            state_d[k] = state_q[k];
            case (state_q[k])
                IDLE: begin
                    if (dispatch && sel == KW'(k)) begin
                        state_d[k] = START;
                        kargs_d[k] = fifo_head[NUM_ARGS-1:0];
                    end
                end
                START: begin
                    if (kern_ap_ready_i[k]) begin
                        if (kern_ap_done_i[k]) begin
                            state_d[k]    = IDLE;
                            done_valid[k] = 1'b1;
                        end else begin
                            state_d[k] = RUN;
                        end
                    end
                end
                RUN: begin
                    if (kern_ap_done_i[k]) begin
                        state_d[k]    = IDLE;
                        done_valid[k] = 1'b1;
                    end
                end
                default: state_d[k] = IDLE;
            endcase
            kern_ap_start_o[k] = (state_q[k] == START);
        end
    end

    // Completion counting, interrupt coalescing and status bits; a set beats a same-cycle W1C.
    always_comb begin
        done_inc = '0;
        for (int k = 0; k < NUM_KERNELS; k++) done_inc = done_inc + 4'(done_valid[k]);
        done_cnt_d = done_cnt_q + 16'(done_inc);
        pend_sum   = pend_q + 9'(done_inc);
        set_done   = (pend_sum >= 9'(thresh_q));
        pend_d     = set_done ? 9'd0 : pend_sum;
        set_ovf    = push_req && fifo_full && !dispatch;
        irq_d      = (irq_q & ~irq_clr) | {set_ovf, set_done};
        irq_out_d  = gie_q && (irq_q != 2'b00);
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gie_q      <= 1'b0;
            stage_q    <= '0;
            done_cnt_q <= '0;
            irq_q      <= '0;
            thresh_q   <= 8'd1;
            pend_q     <= '0;
            bvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            irq_out_q  <= 1'b0;
            rr_q       <= '0;
            kargs_q    <= '0;
            for (int k = 0; k < NUM_KERNELS; k++) state_q[k] <= IDLE;
        end else begin
            gie_q      <= gie_d;
            stage_q    <= stage_d;
            done_cnt_q <= done_cnt_d;
            irq_q      <= irq_d;
            thresh_q   <= thresh_d;
            pend_q     <= pend_d;
            bvalid_q   <= bvalid_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            irq_out_q  <= irq_out_d;
            rr_q       <= rr_d;
            kargs_q    <= kargs_d;
            for (int k = 0; k < NUM_KERNELS; k++) state_q[k] <= state_d[k];
        end
    end

endmodule

// File: tb/tb_custom_hls_job_dispatcher.sv
// tb/tb_custom_hls_job_dispatcher.sv - scoreboard bench for custom_hls_job_dispatcher
module tb_custom_hls_job_dispatcher;

    localparam int NK = 2;
    localparam int NA = 4;
    localparam int QD = 8;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              interrupt;
    logic              awvalid = 0, awready, wvalid = 0, wready;
    logic [AW-1:0]     awaddr = '0;
    logic [31:0]       wdata = '0;
    logic [3:0]        wstrb = '0;
    logic              bvalid, bready = 1;
    logic [1:0]        bresp;
    logic              arvalid = 0, arready;
    logic [AW-1:0]     araddr = '0;
    logic              rvalid, rready = 1;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic [NK-1:0]     start, ready_r = '0, auto_rdy = '0, done_r = '0;
    logic [NK-1:0]     kready;
    logic [NK*NA*32-1:0] kargs;

    assign kready = ready_r | (auto_rdy & start);

    custom_hls_job_dispatcher #(
        .NUM_KERNELS (NK), .NUM_ARGS (NA), .QUEUE_DEPTH (QD), .ADDR_WIDTH (AW)
    ) dut (
        .clk_i                   (clk),
        .rst_ni                  (rst_n),
        .interrupt_o             (interrupt),
        .control_axilite_awvalid (awvalid),
        .control_axilite_awready (awready),
        .control_axilite_awaddr  (awaddr),
        .control_axilite_wvalid  (wvalid),
        .control_axilite_wready  (wready),
        .control_axilite_wdata   (wdata),
        .control_axilite_wstrb   (wstrb),
        .control_axilite_bvalid  (bvalid),
        .control_axilite_bready  (bready),
        .control_axilite_bresp   (bresp),
        .control_axilite_arvalid (arvalid),
        .control_axilite_arready (arready),
        .control_axilite_araddr  (araddr),
        .control_axilite_rvalid  (rvalid),
        .control_axilite_rready  (rready),
        .control_axilite_rdata   (rdata),
        .control_axilite_rresp   (rresp),
        .kern_ap_start_o         (start),
        .kern_ap_ready_i         (kready),
        .kern_ap_done_i          (done_r),
        .kern_args_o             (kargs)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    typedef struct { string name; logic [31:0] data; } rd_exp_t;
    typedef struct { int k; logic [NA*32-1:0] args; } st_exp_t;
    rd_exp_t rq[$];
    st_exp_t sq[$];

    // Read-data monitor.
    always @(negedge clk) begin : rd_mon
        rd_exp_t e;
        if (rst_n && rvalid && rready) begin
            if (rq.size() == 0) begin
                total++; bad++;
                $display("FAIL rd_unexpected got=%h exp=none", rdata);
            end else begin
                e = rq.pop_front();
                check({"rd_", e.name}, rdata, e.data);
                check({"rresp_", e.name}, 32'(rresp), 32'd0);
            end
        end
    end

    // Kernel-start monitor: each rising ap_start must match the next expected dispatch.
    logic [NK-1:0] prev_start = '0;
    always @(negedge clk) begin : st_mon
        st_exp_t e;
        for (int k = 0; k < NK; k++) begin
            if (start[k] && !prev_start[k]) begin
                if (sq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL start_unexpected kernel=%0d got=1 exp=0", k);
                end else begin
                    e = sq.pop_front();
                    check("start_kernel", 32'(k), 32'(e.k));
                    for (int i = 0; i < NA; i++)
                        check($sformatf("start_arg%0d", i), kargs[(k*NA+i)*32 +: 32], e.args[i*32 +: 32]);
                end
            end
        end
        prev_start <= start;
    end

    function automatic logic [NA*32-1:0] mk(input int j);
        logic [NA*32-1:0] a;
        for (int i = 0; i < NA; i++) a[i*32 +: 32] = 32'(j * 256 + i + 1);
        return a;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
        int n;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 50);
        check("wr_accept", 32'(awready), 32'd1);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!(bvalid && bready) && n < 50);
        check("wr_bvalid", 32'(bvalid), 32'd1);
        check("wr_bresp", 32'(bresp), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [7:0] a, input logic [31:0] exp, input string name);
        int n;
        rq.push_back('{name, exp});
        araddr = a; arvalid = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 50);
        @(posedge clk); #1;
        arvalid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rvalid && n < 50);
        check({"rd_handshake_", name}, 32'(rvalid), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic push_job(input int j);
        logic [NA*32-1:0] a;
        a = mk(j);
        for (int i = 0; i < NA; i++) axi_write(8'(8 + 4 * i), a[i*32 +: 32]);
        axi_write(8'h40, 32'd0);
    endtask

    task automatic expect_start(input int k, input int j);
        sq.push_back('{k, mk(j)});
    endtask

    task automatic pulse(input logic [NK-1:0] rdy, input logic [NK-1:0] dn);
        @(posedge clk); #1;
        ready_r = rdy; done_r = dn;
        @(posedge clk); #1;
        ready_r = '0; done_r = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        ready_r = '0; done_r = '0; auto_rdy = '0;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
        #1;
        check("rst_async_start", 32'(start), 32'd0);
        check("rst_async_irq", 32'(interrupt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_args", 32'(|kargs), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_awready", 32'(awready), 32'd0);
        rst_n = 1;
        idle(1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        // Single job to kernel 0, then completion and interrupt.
        do_reset();
        axi_read(8'h4C, 32'd1, "thresh_reset");
        axi_read(8'h04, 32'h0000_0200, "status_reset");
        axi_write(8'h00, 32'd1);
        expect_start(0, 0);
        push_job(0);
        check("t1_start_latency", 32'(start), 32'd1);
        axi_read(8'h04, 32'h0001_0200, "t1_status_busy");
        pulse(2'b01, 2'b00);
        pulse(2'b00, 2'b01);
        idle(2);
        check("t1_irq", 32'(interrupt), 32'd1);
        axi_read(8'h44, 32'd1, "t1_done_cnt");
        axi_read(8'h48, 32'd1, "t1_irq_status");
        axi_write(8'h48, 32'd1);
        check("t1_irq_cleared", 32'(interrupt), 32'd0);

        // Round-robin over two kernels with ap_ready following ap_start.
        do_reset();
        auto_rdy = 2'b11;
        expect_start(0, 0); expect_start(1, 1); expect_start(0, 2); expect_start(1, 3);
        for (int j = 0; j < 4; j++) push_job(j);
        axi_read(8'h04, 32'h0003_0002, "rr_status_2");
        pulse(2'b00, 2'b01);
        idle(3);
        pulse(2'b00, 2'b10);
        idle(3);
        axi_read(8'h04, 32'h0003_0200, "rr_status_0");
        pulse(2'b00, 2'b11);
        idle(3);
        axi_read(8'h44, 32'd4, "rr_done_cnt");

        // Overflow: kernels stuck in START, queue fills, last push dropped.
        do_reset();
        expect_start(0, 0); expect_start(1, 1);
        for (int j = 0; j < 11; j++) push_job(j);
        axi_read(8'h04, 32'h0003_0108, "ovf_status_full");
        axi_read(8'h48, 32'd2, "ovf_irq_status");
        check("ovf_irq_gie_off", 32'(interrupt), 32'd0);
        axi_write(8'h00, 32'd1);
        idle(1);
        check("ovf_irq_gie_on", 32'(interrupt), 32'd1);
        for (int j = 2; j < 10; j++) expect_start(j % 2, j);
        auto_rdy = 2'b11;
        idle(2);
        for (int r = 0; r < 5; r++) begin
            pulse(2'b00, 2'b11);
            idle(4);
        end
        axi_read(8'h04, 32'h0000_0200, "ovf_drained");
        axi_read(8'h44, 32'd10, "ovf_done_cnt");

        // Coalescing with threshold 3.
        do_reset();
        axi_write(8'h00, 32'd1);
        axi_write(8'h4C, 32'd3);
        axi_read(8'h4C, 32'd3, "coal_thresh");
        auto_rdy = 2'b11;
        expect_start(0, 0); expect_start(1, 1); expect_start(0, 2);
        push_job(0);
        push_job(1);
        pulse(2'b00, 2'b01);
        pulse(2'b00, 2'b10);
        idle(3);
        check("coal_irq_2done", 32'(interrupt), 32'd0);
        push_job(2);
        pulse(2'b00, 2'b01);
        idle(2);
        check("coal_irq_3done", 32'(interrupt), 32'd1);
        axi_write(8'h48, 32'd1);
        check("coal_irq_w1c", 32'(interrupt), 32'd0);
        axi_write(8'h4C, 32'd0);
        axi_read(8'h4C, 32'd1, "coal_thresh_zero");

        // ap_ready and ap_done together while in START.
        do_reset();
        expect_start(0, 0);
        push_job(0);
        pulse(2'b01, 2'b01);
        idle(2);
        axi_read(8'h04, 32'h0000_0200, "rd_status_idle");
        axi_read(8'h44, 32'd1, "rd_done_cnt");
        axi_read(8'h48, 32'd1, "rd_irq_status");

        // Flush with 5 queued; running jobs still complete.
        do_reset();
        auto_rdy = 2'b11;
        expect_start(0, 0); expect_start(1, 1);
        for (int j = 0; j < 7; j++) push_job(j);
        axi_read(8'h04, 32'h0003_0005, "fl_status_5");
        axi_write(8'h00, 32'd2);
        axi_read(8'h04, 32'h0003_0200, "fl_status_flushed");
        axi_read(8'h00, 32'd0, "fl_ctrl");
        pulse(2'b00, 2'b11);
        idle(4);
        axi_read(8'h04, 32'h0000_0200, "fl_status_idle");
        axi_read(8'h44, 32'd2, "fl_done_cnt");

        // Reset while kernels are running with a pending interrupt.
        do_reset();
        axi_write(8'h00, 32'd1);
        auto_rdy = 2'b11;
        expect_start(0, 0); expect_start(1, 1); expect_start(0, 2);
        for (int j = 0; j < 3; j++) push_job(j);
        pulse(2'b00, 2'b01);
        idle(3);
        check("mr_irq_before", 32'(interrupt), 32'd1);
        axi_read(8'h04, 32'h0003_0200, "mr_status_run");
        do_reset();
        axi_read(8'h04, 32'h0000_0200, "mr_status_after");
        axi_read(8'h44, 32'd0, "mr_done_cnt");
        axi_read(8'h4C, 32'd1, "mr_thresh");

        // Write-response backpressure, byte strobes and unmapped addresses.
        axi_write(8'h08, 32'h1122_3344);
        bready = 0;
        awaddr = 8'h08; wdata = 32'hAABB_CCDD; wstrb = 4'b0101; awvalid = 1; wvalid = 1;
        @(negedge clk);
        check("bp_first_accept", 32'(awready), 32'd1);
        @(posedge clk); #1;
        awaddr = 8'h0C; wdata = 32'h5566_7788; wstrb = 4'hF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_bvalid_held", 32'(bvalid), 32'd1);
            check("bp_awready_low", 32'(awready), 32'd0);
        end
        @(posedge clk); #1;
        bready = 1;
        @(negedge clk);
        check("bp_awready_release", 32'(awready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_second_accept", 32'(awready), 32'd1);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        idle(2);
        axi_read(8'h08, 32'h11BB_33DD, "bp_arg0_strb");
        axi_read(8'h0C, 32'h5566_7788, "bp_arg1");
        axi_write(8'h7C, 32'hFFFF_FFFF);
        axi_read(8'h7C, 32'd0, "unmapped");
        axi_read(8'h40, 32'd0, "push_reads_zero");
        axi_read(8'h04, 32'h0000_0200, "unmapped_no_effect");

        idle(4);
        check("start_queue_drained", 32'(sq.size()), 32'd0);
        check("read_queue_drained", 32'(rq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
